// File: rtl/aurora_reset_seq_if.sv
// Signal bundle between the Aurora reset sequencer and the GT/MMCM/core it controls.
// master = sequencer side, slave = the lane logic being sequenced.
interface aurora_reset_seq_if;
    logic       PLL_LOCKED;
    logic       MMCM_NOT_LOCKED;
    logic       CHANNEL_UP;
    logic       SOFT_RESET_REQ;
    logic       GT_RESET;
    logic       TX_CLK_CLR;
    logic       CLK_LOCKED;
    logic       RESET_PB;
    logic       LINK_READY;
    logic [2:0] SEQ_STATE;
    logic [7:0] RETRY_COUNT;

    modport master (
        input  PLL_LOCKED, MMCM_NOT_LOCKED, CHANNEL_UP, SOFT_RESET_REQ,
        output GT_RESET, TX_CLK_CLR, CLK_LOCKED, RESET_PB, LINK_READY,
               SEQ_STATE, RETRY_COUNT
    );

    modport slave (
        output PLL_LOCKED, MMCM_NOT_LOCKED, CHANNEL_UP, SOFT_RESET_REQ,
        input  GT_RESET, TX_CLK_CLR, CLK_LOCKED, RESET_PB, LINK_READY,
               SEQ_STATE, RETRY_COUNT
    );
endinterface

// File: rtl/aurora_reset_seq.sv
// Power-up/recovery reset sequencer for one Aurora lane, clocked by the free-running INIT_CLK.
// Define AURORA_RESET_RETRY_LIMIT_EN to park in S_FAIL once MAX_RETRIES retries have occurred.
module aurora_reset_seq #(
    parameter int GT_RESET_CYCLES        = 128,
    parameter int PB_HOLD_CYCLES         = 256,
    parameter int LOCK_TIMEOUT_CYCLES    = 1048576,
    parameter int CHANNEL_TIMEOUT_CYCLES = 4194304,
    parameter int CNT_WIDTH              = 24,
    parameter int MAX_RETRIES            = 8
) (
    input  logic                      INIT_CLK,
    input  logic                      RESET,
    aurora_reset_seq_if.master        seq_if
);

    typedef enum logic [2:0] {
        S_GT_RST    = 3'd0,
        S_WAIT_PLL  = 3'd1,
        S_WAIT_MMCM = 3'd2,
        S_PB_HOLD   = 3'd3,
        S_WAIT_CHAN = 3'd4,
`ifdef AURORA_RESET_RETRY_LIMIT_EN
        S_FAIL      = 3'd6,
`endif
        S_RUN       = 3'd5
    } state_e;

    localparam logic [CNT_WIDTH-1:0] GtExp   = CNT_WIDTH'(GT_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] PbExp   = CNT_WIDTH'(PB_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LockExp = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ChanExp = CNT_WIDTH'(CHANNEL_TIMEOUT_CYCLES - 1);

    // Elaboration guards: the shared timer must reach every expiry value.
    if (longint'(CHANNEL_TIMEOUT_CYCLES) > (64'd1 << CNT_WIDTH) ||
        longint'(LOCK_TIMEOUT_CYCLES)    > (64'd1 << CNT_WIDTH) ||
        longint'(PB_HOLD_CYCLES)         > (64'd1 << CNT_WIDTH) ||
        longint'(GT_RESET_CYCLES)        > (64'd1 << CNT_WIDTH))
        $error("aurora_reset_seq: CNT_WIDTH too small");
    if (MAX_RETRIES < 1) $error("aurora_reset_seq: MAX_RETRIES must be >= 1");

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic [7:0]             retry_q, retry_d, retry_inc;
    logic [1:0]             pll_sync_q, mlock_sync_q, chan_sync_q;
    logic [4:0]             outs_q, outs_d;   // GT_RESET/TX_CLK_CLR/CLK_LOCKED/RESET_PB/LINK_READY
    logic                   pll_s, mlock_s, chan_s, lock_lost, retry_req;

    assign pll_s     = pll_sync_q[1];
    assign mlock_s   = mlock_sync_q[1];
    assign chan_s    = chan_sync_q[1];
    assign lock_lost = !pll_s || !mlock_s;
    assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

    always_ff @(posedge INIT_CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_GT_RST;
            timer_q      <= '0;
            retry_q      <= '0;
            outs_q       <= 5'b11010;
            pll_sync_q   <= '0;
            mlock_sync_q <= '0;
            chan_sync_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            outs_q       <= outs_d;
            pll_sync_q   <= {pll_sync_q[0], seq_if.PLL_LOCKED};
            mlock_sync_q <= {mlock_sync_q[0], !seq_if.MMCM_NOT_LOCKED};
            chan_sync_q  <= {chan_sync_q[0], seq_if.CHANNEL_UP};
        end
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        retry_req = 1'b0;
        unique case (state_q)
            S_GT_RST:    if (timer_q == GtExp) state_d = S_WAIT_PLL;
            S_WAIT_PLL:  if (pll_s) state_d = S_WAIT_MMCM;
                         else if (timer_q == LockExp) retry_req = 1'b1;
            S_WAIT_MMCM: if (!pll_s) retry_req = 1'b1;
                         else if (mlock_s) state_d = S_PB_HOLD;
                         else if (timer_q == LockExp) retry_req = 1'b1;
            S_PB_HOLD:   if (lock_lost) retry_req = 1'b1;
                         else if (timer_q == PbExp) state_d = S_WAIT_CHAN;
            S_WAIT_CHAN: if (lock_lost) retry_req = 1'b1;
                         else if (chan_s) state_d = S_RUN;
                         else if (timer_q == ChanExp) retry_req = 1'b1;
            S_RUN:       if (lock_lost) retry_req = 1'b1;
                         else if (!chan_s) begin
                             state_d = S_PB_HOLD;
                             retry_d = retry_inc;
                         end
`ifdef AURORA_RESET_RETRY_LIMIT_EN
            S_FAIL:      state_d = S_FAIL;
`endif
            default:     state_d = S_GT_RST;
        endcase
        if (retry_req) begin
            retry_d = retry_inc;
            state_d = S_GT_RST;
`ifdef AURORA_RESET_RETRY_LIMIT_EN
            if (int'(retry_inc) >= MAX_RETRIES) state_d = S_FAIL;
`endif
        end
        // Soft reset outranks everything and never counts as a retry.
        if (seq_if.SOFT_RESET_REQ) begin
            state_d = S_GT_RST;
            retry_d = retry_q;
`ifdef AURORA_RESET_RETRY_LIMIT_EN
            if (state_q == S_FAIL) retry_d = '0;
`endif
        end
        timer_d = (state_d != state_q || seq_if.SOFT_RESET_REQ) ? '0 : timer_q + 1'b1;
    end

    always_comb begin
        outs_d = 5'b11010;
        case (state_d)
            S_GT_RST:    outs_d = 5'b11010;
            S_WAIT_PLL:  outs_d = 5'b01010;
            S_WAIT_MMCM: outs_d = 5'b00110;
            S_PB_HOLD:   outs_d = 5'b00110;
            S_WAIT_CHAN: outs_d = 5'b00100;
            S_RUN:       outs_d = 5'b00101;
            default:     outs_d = 5'b11010;
        endcase
    end

    assign seq_if.GT_RESET    = outs_q[4];
    assign seq_if.TX_CLK_CLR  = outs_q[3];
    assign seq_if.CLK_LOCKED  = outs_q[2];
    assign seq_if.RESET_PB    = outs_q[1];
    assign seq_if.LINK_READY  = outs_q[0];
    assign seq_if.SEQ_STATE   = state_q;
    assign seq_if.RETRY_COUNT = retry_q;

endmodule

// File: tb/tb_aurora_reset_seq.sv
// Directed bench for aurora_reset_seq: bring-up, timeouts, lock/channel loss, soft reset.
// Expected values are hand-derived cycle offsets from RESET release.
module tb_aurora_reset_seq;
`ifdef AURORA_RESET_RETRY_LIMIT_EN
    localparam int MR = 3;
`else
    localparam int MR = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    aurora_reset_seq_if u_if ();

    aurora_reset_seq #(
        .GT_RESET_CYCLES(8), .PB_HOLD_CYCLES(16), .LOCK_TIMEOUT_CYCLES(64),
        .CHANNEL_TIMEOUT_CYCLES(128), .CNT_WIDTH(24), .MAX_RETRIES(MR)
    ) u_dut (
        .INIT_CLK (clk),
        .RESET    (rst),
        .seq_if   (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic restart();
        @(posedge clk); #1;
        rst = 1'b1;
        u_if.PLL_LOCKED = 1'b0; u_if.MMCM_NOT_LOCKED = 1'b1;
        u_if.CHANNEL_UP = 1'b0; u_if.SOFT_RESET_REQ  = 1'b0;
        #1;
        chk("async_rst_state", 32'(u_if.SEQ_STATE), 0);
        chk("async_rst_retry", 32'(u_if.RETRY_COUNT), 0);
        chk("async_rst_gt", 32'(u_if.GT_RESET), 1);
        tick(3);
        rst = 1'b0;   // next rising edge is E0
    endtask

    initial begin
        u_if.PLL_LOCKED = 1'b0; u_if.MMCM_NOT_LOCKED = 1'b1;
        u_if.CHANNEL_UP = 1'b0; u_if.SOFT_RESET_REQ  = 1'b0;
        tick(3);
        chk("rst_gt",    32'(u_if.GT_RESET), 1);
        chk("rst_txclr", 32'(u_if.TX_CLK_CLR), 1);
        chk("rst_clklk", 32'(u_if.CLK_LOCKED), 0);
        chk("rst_pb",    32'(u_if.RESET_PB), 1);
        chk("rst_ready", 32'(u_if.LINK_READY), 0);
        chk("rst_state", 32'(u_if.SEQ_STATE), 0);
        chk("rst_retry", 32'(u_if.RETRY_COUNT), 0);
        rst = 1'b0;

        // Clean bring-up
        tick(7);  chk("up_gt_hold", 32'(u_if.GT_RESET), 1);           // E6
        tick(1);  chk("up_gt_fall", 32'(u_if.GT_RESET), 0);           // E7
                  chk("up_st_pll", 32'(u_if.SEQ_STATE), 1);
        tick(12); u_if.PLL_LOCKED = 1'b1;                              // E19
        tick(2);  chk("up_clklk_early", 32'(u_if.CLK_LOCKED), 0);     // E21
        tick(1);  chk("up_clklk", 32'(u_if.CLK_LOCKED), 1);           // E22
                  chk("up_txclr", 32'(u_if.TX_CLK_CLR), 0);
                  chk("up_st_mmcm", 32'(u_if.SEQ_STATE), 2);
        tick(17); u_if.MMCM_NOT_LOCKED = 1'b0;                         // E39
        tick(3);  chk("up_st_pb", 32'(u_if.SEQ_STATE), 3);            // E42
        tick(15); chk("up_pb_hold", 32'(u_if.RESET_PB), 1);           // E57
        tick(1);  chk("up_pb_fall", 32'(u_if.RESET_PB), 0);           // E58
                  chk("up_st_chan", 32'(u_if.SEQ_STATE), 4);
        tick(21); u_if.CHANNEL_UP = 1'b1;                              // E79
        tick(2);  chk("up_ready_early", 32'(u_if.LINK_READY), 0);     // E81
        tick(1);  chk("up_ready", 32'(u_if.LINK_READY), 1);           // E82
                  chk("up_st_run", 32'(u_if.SEQ_STATE), 5);
                  chk("up_retry", 32'(u_if.RETRY_COUNT), 0);

        // CHANNEL_UP drop in S_RUN with locks held
        tick(10); u_if.CHANNEL_UP = 1'b0;                              // E92
        tick(3);  chk("cd_st_pb", 32'(u_if.SEQ_STATE), 3);            // E95
                  chk("cd_pb", 32'(u_if.RESET_PB), 1);
                  chk("cd_gt", 32'(u_if.GT_RESET), 0);
                  chk("cd_retry", 32'(u_if.RETRY_COUNT), 1);
                  chk("cd_ready", 32'(u_if.LINK_READY), 0);
        tick(15); chk("cd_pb_hold", 32'(u_if.RESET_PB), 1);           // E110
        tick(1);  chk("cd_pb_fall", 32'(u_if.RESET_PB), 0);           // E111
                  chk("cd_st_chan", 32'(u_if.SEQ_STATE), 4);
        u_if.CHANNEL_UP = 1'b1;
        tick(3);  chk("cd_rerun", 32'(u_if.SEQ_STATE), 5);            // E114

        // MMCM unlock pulse in S_RUN
        tick(5);  u_if.MMCM_NOT_LOCKED = 1'b1;                         // E119
        tick(2);  chk("mu_ready_early", 32'(u_if.LINK_READY), 1);     // E121
        tick(1);  chk("mu_gt", 32'(u_if.GT_RESET), 1);                // E122
                  chk("mu_clklk", 32'(u_if.CLK_LOCKED), 0);
                  chk("mu_ready", 32'(u_if.LINK_READY), 0);
                  chk("mu_retry", 32'(u_if.RETRY_COUNT), 2);
                  chk("mu_state", 32'(u_if.SEQ_STATE), 0);
        tick(2);  u_if.MMCM_NOT_LOCKED = 1'b0;                         // E124

        // PLL timeout: WAIT_PLL spans E7..E71, then every 72 cycles
        restart();
        tick(8);  chk("pt_st_pll", 32'(u_if.SEQ_STATE), 1);           // E7
        tick(63); chk("pt_last", 32'(u_if.SEQ_STATE), 1);             // E70
                  chk("pt_last_gt", 32'(u_if.GT_RESET), 0);
        tick(1);  chk("pt1_gt", 32'(u_if.GT_RESET), 1);               // E71
                  chk("pt1_state", 32'(u_if.SEQ_STATE), 0);
                  chk("pt1_retry", 32'(u_if.RETRY_COUNT), 1);
        tick(8);  chk("pt1_st_pll", 32'(u_if.SEQ_STATE), 1);          // E79
        tick(64); chk("pt2_retry", 32'(u_if.RETRY_COUNT), 2);         // E143
                  chk("pt2_state", 32'(u_if.SEQ_STATE), 0);
        tick(72);                                                      // E215
        chk("pt3_retry", 32'(u_if.RETRY_COUNT), 3);
`ifdef AURORA_RESET_RETRY_LIMIT_EN
        chk("lim_state", 32'(u_if.SEQ_STATE), 6);
        chk("lim_gt", 32'(u_if.GT_RESET), 1);
        tick(100);
        chk("lim_stay", 32'(u_if.SEQ_STATE), 6);
        chk("lim_pb", 32'(u_if.RESET_PB), 1);
        u_if.SOFT_RESET_REQ = 1'b1;
        tick(1);  u_if.SOFT_RESET_REQ = 1'b0;
        chk("lim_soft_state", 32'(u_if.SEQ_STATE), 0);
        chk("lim_soft_retry", 32'(u_if.RETRY_COUNT), 0);
`else
        chk("pt3_state", 32'(u_if.SEQ_STATE), 0);
`endif

        // Soft reset on the WAIT_PLL expiry cycle wins over the timeout
        restart();
        tick(71); u_if.SOFT_RESET_REQ = 1'b1;                          // E70
        tick(1);  u_if.SOFT_RESET_REQ = 1'b0;                          // E71
        chk("sc_state", 32'(u_if.SEQ_STATE), 0);
        chk("sc_retry", 32'(u_if.RETRY_COUNT), 0);
        chk("sc_gt", 32'(u_if.GT_RESET), 1);
        tick(7);  chk("sc_gt_hold", 32'(u_if.SEQ_STATE), 0);          // E78
        tick(1);  chk("sc_st_pll", 32'(u_if.SEQ_STATE), 1);           // E79

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
